issue_hazard_ctrl: RTL

//  Issue/interlock controller for the dual-issue ID->exe0 boundary. Bypass covers only results already in the
//  exe0_exe1/exe1_wb latches, so this block tracks long-latency writes (load/mul/div) in a per-register

---
 rtl/issue_hazard_ctrl.sv | 260 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/issue_hazard_ctrl.sv
// ----------------------------------------------------------------------------
// issue_hazard_ctrl
// Issue/interlock controller for the dual-issue ID->exe0 boundary.
// The bypass network only covers results already sitting in the exe0_exe1 and
// exe1_wb latches. This block therefore tracks long-latency writes
// (load/mul/div) in a per-register countdown scoreboard. Each cycle it decides
// whether slot0, slot1 or neither enters exe0. It splits pairs that cannot go
// together, and it sequences the single iterative divider.
//
// Ports
//   clk_i, rstn_i             clock, asynchronous active-low reset
//   valid{0,1}_i              ID slot holds an instruction
//   use_r{j,k,d}{0,1}_i       slot reads rj / rk / rd as a source
//   r{j,k,d}{0,1}_i [4:0]     register numbers; rd is also the destination
//   we{0,1}_i                 slot writes rd
//   type{0,1}_i [1:0]         00 alu, 01 load, 10 mul, 11 div
//   mem_stall_i               dcache miss, backend frozen
//   flush_i                   exe1 redirect, kill whatever entered exe0 last
//   issue{0,1}_o              slot enters exe0 this cycle (combinational)
//   stall_id_o                hold ID / register-read stage (combinational)
//   div_busy_o                divider is iterating (registered)
// ----------------------------------------------------------------------------
module issue_hazard_ctrl #(
    parameter int unsigned LOAD_LAT = 2,
    parameter int unsigned MUL_LAT  = 2,
    parameter int unsigned DIV_LAT  = 34
) (
    input  logic       clk_i,
    input  logic       rstn_i,
    input  logic       valid0_i,
    input  logic       use_rj0_i,
    input  logic       use_rk0_i,
    input  logic       use_rd0_i,
    input  logic [4:0] rj0_i,
    input  logic [4:0] rk0_i,
    input  logic [4:0] rd0_i,
    input  logic       we0_i,
    input  logic [1:0] type0_i,
    input  logic       valid1_i,
    input  logic       use_rj1_i,
    input  logic       use_rk1_i,
    input  logic       use_rd1_i,
    input  logic [4:0] rj1_i,
    input  logic [4:0] rk1_i,
    input  logic [4:0] rd1_i,
    input  logic       we1_i,
    input  logic [1:0] type1_i,
    input  logic       mem_stall_i,
    input  logic       flush_i,
    output logic       issue0_o,
    output logic       issue1_o,
    output logic       stall_id_o,
    output logic       div_busy_o
);

    localparam int unsigned   CW        = $clog2(DIV_LAT + 1);
    localparam logic [CW-1:0] CNT_ZERO  = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [1:0]    TYPE_ALU  = 2'b00;
    localparam logic [1:0]    TYPE_LOAD = 2'b01;
    localparam logic [1:0]    TYPE_MUL  = 2'b10;
    localparam logic [1:0]    TYPE_DIV  = 2'b11;

    typedef enum logic [0:0] {
        DIV_IDLE = 1'b0,
        DIV_BUSY = 1'b1
    } div_state_e;

    logic [CW-1:0] cnt_q [1:31];
    logic [CW-1:0] cnt_d [1:31];
    logic [31:1]   young_q, young_d;
    div_state_e    div_state_q, div_state_d;
    logic [CW-1:0] dcnt_q, dcnt_d;
    logic          div_young_q, div_young_d;

    logic [31:0]   pend_s;
    logic          div_busy_s;
    logic          haz0_s, haz1_s, pair_conflict_s;
    logic          issue0_s, issue1_s, stall_id_s;
    logic          wr0_s, wr1_s, div_issue_s, advance_s;

    // Countdown loaded at issue for a given instruction class.
    function automatic logic [CW-1:0] lat_of(input logic [1:0] t);
        logic [CW-1:0] l;
        case (t)
            TYPE_LOAD: l = CW'(LOAD_LAT);
            TYPE_MUL:  l = CW'(MUL_LAT);
            TYPE_DIV:  l = CW'(DIV_LAT);
            default:   l = CNT_ZERO;
        endcase
        return l;
    endfunction

    // Slot-local hazard. pend[0] is always clear, so r0 never matches.
    // type[1] covers both mul and div, which share the busy divider check.
    function automatic logic slot_haz(input logic [31:0] pend,
                                      input logic        use_rj,
                                      input logic [4:0]  rj,
                                      input logic        use_rk,
                                      input logic [4:0]  rk,
                                      input logic        use_rd,
                                      input logic [4:0]  rd,
                                      input logic        we,
                                      input logic [1:0]  t,
                                      input logic        dbusy);
        return (use_rj & pend[rj]) | (use_rk & pend[rk]) | (use_rd & pend[rd]) |
               (we & pend[rd]) | (t[1] & dbusy);
    endfunction

    // True when a slot reads register r through any of its source ports.
    function automatic logic reads_reg(input logic       use_rj,
                                       input logic [4:0] rj,
                                       input logic       use_rk,
                                       input logic [4:0] rk,
                                       input logic       use_rd,
                                       input logic [4:0] rd,
                                       input logic [4:0] r);
        return (use_rj & (rj == r)) | (use_rk & (rk == r)) | (use_rd & (rd == r));
    endfunction

    // Pending view of the scoreboard; r0 is never tracked.
    always_comb begin
        pend_s = 32'b0;
        for (int r = 1; r < 32; r++) begin
            pend_s[r] = (cnt_q[r] != CNT_ZERO);
        end
    end

    // Issue decision, pair split and ID stall.
    always_comb begin
        div_busy_s = (div_state_q == DIV_BUSY);
        haz0_s = slot_haz(pend_s, use_rj0_i, rj0_i, use_rk0_i, rk0_i, use_rd0_i, rd0_i,
                          we0_i, type0_i, div_busy_s);
        haz1_s = slot_haz(pend_s, use_rj1_i, rj1_i, use_rk1_i, rk1_i, use_rd1_i, rd1_i,
                          we1_i, type1_i, div_busy_s);
        // Slot1 cannot see slot0's result within the same stage. A same-stage
        // double write resolves in slot0's favour in the bypass, so slot1's
        // write would be the one architecturally lost. Only one mul/div unit.
        pair_conflict_s =
            (we0_i & (rd0_i != 5'd0) &
             reads_reg(use_rj1_i, rj1_i, use_rk1_i, rk1_i, use_rd1_i, rd1_i, rd0_i)) |
            (we0_i & we1_i & (rd0_i == rd1_i) & (rd0_i != 5'd0)) |
            (type0_i[1] & type1_i[1]);
        issue0_s    = rstn_i & valid0_i & ~haz0_s & ~mem_stall_i & ~flush_i;
        issue1_s    = issue0_s & valid1_i & ~haz1_s & ~pair_conflict_s;
        stall_id_s  = rstn_i & valid0_i & ~(issue0_s & (issue1_s | ~valid1_i));
        wr0_s       = issue0_s & we0_i & (rd0_i != 5'd0) & (type0_i != TYPE_ALU);
        wr1_s       = issue1_s & we1_i & (rd1_i != 5'd0) & (type1_i != TYPE_ALU);
        div_issue_s = (issue0_s & (type0_i == TYPE_DIV)) | (issue1_s & (type1_i == TYPE_DIV));
        advance_s   = ~mem_stall_i & ~flush_i;
    end

    assign issue0_o   = issue0_s;
    assign issue1_o   = issue1_s;
    assign stall_id_o = stall_id_s;
    assign div_busy_o = div_busy_s;

    // Scoreboard next state: flush kills young entries, stall freezes, else count down.
    always_comb begin
        young_d = young_q;
        for (int r = 1; r < 32; r++) begin
            cnt_d[r] = cnt_q[r];
        end
        if (flush_i) begin
            // Only entries written by the killed exe0 content are young.
            for (int r = 1; r < 32; r++) begin
                if (young_q[r]) begin
                    cnt_d[r] = CNT_ZERO;
                end else begin
                    cnt_d[r] = cnt_q[r];
                end
            end
            young_d = 31'b0;
        end else if (advance_s) begin
            young_d = 31'b0;
            for (int r = 1; r < 32; r++) begin
                if (wr0_s && (rd0_i == 5'(r))) begin
                    cnt_d[r]   = lat_of(type0_i);
                    young_d[r] = 1'b1;
                end else if (wr1_s && (rd1_i == 5'(r))) begin
                    cnt_d[r]   = lat_of(type1_i);
                    young_d[r] = 1'b1;
                end else if (pend_s[r]) begin
                    cnt_d[r] = cnt_q[r] - CNT_ONE;
                end else begin
                    cnt_d[r] = cnt_q[r];
                end
            end
        end else begin
            young_d = young_q;
        end
    end

    // Divider sequencer next state; freezes and flushes like the scoreboard.
    always_comb begin
        div_state_d = div_state_q;
        dcnt_d      = dcnt_q;
        div_young_d = div_young_q;
        if (flush_i) begin
            if (div_young_q) begin
                div_state_d = DIV_IDLE;
                dcnt_d      = CNT_ZERO;
            end else begin
                div_state_d = div_state_q;
            end
            div_young_d = 1'b0;
        end else if (advance_s) begin
            div_young_d = 1'b0;
            case (div_state_q)
                DIV_IDLE: begin
                    if (div_issue_s) begin
                        div_state_d = DIV_BUSY;
                        dcnt_d      = CW'(DIV_LAT);
                        div_young_d = 1'b1;
                    end else begin
                        div_state_d = DIV_IDLE;
                    end
                end
                DIV_BUSY: begin
                    // Leave BUSY on the same edge where the countdown hits 0,
                    // so busy lines up with the scoreboard entry of the div.
                    if (dcnt_q <= CNT_ONE) begin
                        div_state_d = DIV_IDLE;
                        dcnt_d      = CNT_ZERO;
                    end else begin
                        dcnt_d = dcnt_q - CNT_ONE;
                    end
                end
                default: begin
                    div_state_d = DIV_IDLE;
                    dcnt_d      = CNT_ZERO;
                end
            endcase
        end else begin
            div_young_d = div_young_q;
        end
    end

    // State registers.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            for (int r = 1; r < 32; r++) begin
                cnt_q[r] <= CNT_ZERO;
            end
            young_q     <= 31'b0;
            div_state_q <= DIV_IDLE;
            dcnt_q      <= CNT_ZERO;
            div_young_q <= 1'b0;
        end else begin
            for (int r = 1; r < 32; r++) begin
                cnt_q[r] <= cnt_d[r];
            end
            young_q     <= young_d;
            div_state_q <= div_state_d;
            dcnt_q      <= dcnt_d;
            div_young_q <= div_young_d;
        end
    end

endmodule
